// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port controller for the 80x60 display.
// Shares the single write port between CPU pixel writes and a rectangle-fill
// engine. Fairness: whoever lost the most recent CPU/fill conflict wins the next.
module fb_write_arbiter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cpu_req_i,
   input  logic [12:0] cpu_wa_i,
   input  logic [7:0]  cpu_wd_i,
   output logic        cpu_ack_o,
   input  logic        fill_start_i,
   input  logic [6:0]  fill_x_i,
   input  logic [5:0]  fill_y_i,
   input  logic [6:0]  fill_w_i,
   input  logic [5:0]  fill_h_i,
   input  logic [7:0]  fill_color_i,
   output logic        fill_busy_o,
   output logic        fill_done_o,
   output logic [12:0] fb_wa_o,
   output logic [7:0]  fb_wd_o,
   output logic        fb_we_o
);

   localparam logic [7:0] Cols = 8'd80;
   localparam logic [7:0] Rows = 8'd60;

   typedef enum logic [1:0] {StIdle, StFill, StFinish} state_e;

   state_e      state_q, state_d;
   logic [6:0]  x0_q, x0_d;
   // End coordinates and scan counters are 8 bits so X+W never wraps.
   logic [7:0]  end_x_q, end_x_d;
   logic [7:0]  end_y_q, end_y_d;
   logic [7:0]  cx_q, cx_d;
   logic [7:0]  cy_q, cy_d;
   logic [7:0]  color_q, color_d;
   logic        last_cpu_q, last_cpu_d;  // 1: CPU won the latest conflict
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        we_q, we_d;
   logic [12:0] wa_q, wa_d;
   logic [7:0]  wd_q, wd_d;

   logic        in_range, fill_req, cpu_elig, cpu_gnt, fill_gnt;
   logic        advance, row_end, last_pix;
   logic [7:0]  cx_inc, cy_inc;

   // Arbitration between the CPU and the fill engine for this cycle.
   always_comb begin
      cx_inc   = cx_q + 8'd1;
      cy_inc   = cy_q + 8'd1;
      in_range = (cx_q < Cols) && (cy_q < Rows);
      fill_req = (state_q == StFill) && in_range;
      // A held request must not be granted again in its ACK cycle.
      cpu_elig = cpu_req_i && !ack_q;
      cpu_gnt  = cpu_elig && (!fill_req || !last_cpu_q);
      fill_gnt = fill_req && !cpu_gnt;
      // Clipped pixels step on without requesting the port.
      advance  = (state_q == StFill) && (fill_gnt || !in_range);
      row_end  = (cx_inc == end_x_q);
      last_pix = row_end && (cy_inc == end_y_q);
   end

   // Next-state for the fill FSM, scan counters and registered port outputs.
   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      end_x_d    = end_x_q;
      end_y_d    = end_y_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      color_d    = color_q;
      last_cpu_d = last_cpu_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ack_d      = cpu_gnt;
      we_d       = cpu_gnt || fill_gnt;
      wa_d       = wa_q;
      wd_d       = wd_q;

      if (cpu_elig && fill_req) begin
         last_cpu_d = cpu_gnt;
      end

      if (cpu_gnt) begin
         wa_d = cpu_wa_i;
         wd_d = cpu_wd_i;
      end else if (fill_gnt) begin
         wa_d = {cy_q[5:0], cx_q[6:0]};
         wd_d = color_q;
      end

      case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (fill_start_i) begin
               x0_d    = fill_x_i;
               end_x_d = {1'b0, fill_x_i} + {1'b0, fill_w_i};
               end_y_d = {2'b00, fill_y_i} + {2'b00, fill_h_i};
               cx_d    = {1'b0, fill_x_i};
               cy_d    = {2'b00, fill_y_i};
               color_d = fill_color_i;
               busy_d  = 1'b1;
               if ((fill_w_i == 7'd0) || (fill_h_i == 6'd0)) begin
                  state_d = StFinish;
                  done_d  = 1'b1;
               end else begin
                  state_d = StFill;
               end
            end
         end
         StFill: begin
            busy_d = 1'b1;
            if (advance) begin
               if (row_end) begin
                  cx_d = {1'b0, x0_q};
                  cy_d = cy_inc;
                  if (last_pix) begin
                     state_d = StFinish;
                     done_d  = 1'b1;
                  end
               end else begin
                  cx_d = cx_inc;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         x0_q       <= '0;
         end_x_q    <= '0;
         end_y_q    <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         color_q    <= '0;
         last_cpu_q <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         end_x_q    <= end_x_d;
         end_y_q    <= end_y_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         color_q    <= color_d;
         last_cpu_q <= last_cpu_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
      end
   end

   assign cpu_ack_o   = ack_q;
   assign fill_busy_o = busy_q;
   assign fill_done_o = done_q;
   assign fb_we_o     = we_q;
   assign fb_wa_o     = wa_q;
   assign fb_wd_o     = wd_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus a
// randomized run scored against a pixel-list reference model.
module tb_fb_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n, cpu_req, fill_start;
   logic [12:0] cpu_wa;
   logic [7:0]  cpu_wd, fill_color;
   logic [6:0]  fill_x, fill_w;
   logic [5:0]  fill_y, fill_h;
   logic        cpu_ack, fill_busy, fill_done, fb_we;
   logic [12:0] fb_wa;
   logic [7:0]  fb_wd;

   int checks = 0;
   int failures = 0;

   // Reference model: a fill is a list of pixel slots in scan order,
   // each either an in-range address or -1 for a clipped slot.
   int          m_pix[$];
   logic        m_filling = 1'b0, m_finish = 1'b0, m_last_cpu = 1'b0;
   logic [7:0]  m_color = '0;
   logic        e_ack = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_we = 1'b0;
   logic [12:0] e_wa = '0;
   logic [7:0]  e_wd = '0;

   always #5 clk = ~clk;

   fb_write_arbiter dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cpu_req_i    (cpu_req),
      .cpu_wa_i     (cpu_wa),
      .cpu_wd_i     (cpu_wd),
      .cpu_ack_o    (cpu_ack),
      .fill_start_i (fill_start),
      .fill_x_i     (fill_x),
      .fill_y_i     (fill_y),
      .fill_w_i     (fill_w),
      .fill_h_i     (fill_h),
      .fill_color_i (fill_color),
      .fill_busy_o  (fill_busy),
      .fill_done_o  (fill_done),
      .fb_wa_o      (fb_wa),
      .fb_wd_o      (fb_wd),
      .fb_we_o      (fb_we)
   );

   function automatic logic [12:0] pix(input int y, input int x);
      return 13'(y * 128 + x);
   endfunction

   // Advance the model by one clock using the inputs about to be sampled.
   task automatic model_step();
      logic fill_req, cpu_el, cpu_win, fill_win;
      if (!rst_n) begin
         e_ack = 0; e_busy = 0; e_done = 0; e_we = 0; e_wa = '0; e_wd = '0;
         m_last_cpu = 0; m_filling = 0; m_finish = 0;
         m_pix.delete();
         return;
      end
      fill_req = m_filling && (m_pix.size() > 0) && (m_pix[0] >= 0);
      cpu_el   = cpu_req && !e_ack;
      cpu_win  = cpu_el && (!fill_req || !m_last_cpu);
      fill_win = fill_req && !cpu_win;
      if (cpu_el && fill_req) m_last_cpu = cpu_win;
      e_we  = cpu_win || fill_win;
      e_ack = cpu_win;
      if (cpu_win) begin
         e_wa = cpu_wa;
         e_wd = cpu_wd;
      end else if (fill_win) begin
         e_wa = 13'(m_pix[0]);
         e_wd = m_color;
      end
      if (m_finish) begin
         m_finish = 0;
         e_busy   = 0;
         e_done   = 0;
      end else if (m_filling) begin
         if (fill_win || (m_pix[0] < 0)) void'(m_pix.pop_front());
         if (m_pix.size() == 0) begin
            m_filling = 0;
            m_finish  = 1;
         end
         e_busy = 1;
         e_done = m_finish;
      end else if (fill_start) begin
         for (int r = 0; r < int'(fill_h); r++) begin
            for (int c = 0; c < int'(fill_w); c++) begin
               int xx, yy;
               xx = int'(fill_x) + c;
               yy = int'(fill_y) + r;
               if (xx < 80 && yy < 60) m_pix.push_back(yy * 128 + xx);
               else m_pix.push_back(-1);
            end
         end
         m_color = fill_color;
         if (m_pix.size() == 0) m_finish = 1;
         else m_filling = 1;
         e_busy = 1;
         e_done = m_finish;
      end else begin
         e_busy = 0;
         e_done = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fill(input int x, input int y, input int w, input int h,
                           input logic [7:0] col);
      fill_x = 7'(x); fill_y = 6'(y); fill_w = 7'(w); fill_h = 6'(h); fill_color = col;
   endtask

   task automatic test_reset();
      rst_n = 0; cpu_req = 1; cpu_wa = 13'h1234; cpu_wd = 8'h55; fill_start = 1;
      set_fill(1, 1, 2, 2, 8'hFF);
      repeat (3) tick();
      checks++;
      if ({cpu_ack, fill_busy, fill_done, fb_we} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got ack=%b busy=%b done=%b we=%b want 0000",
                  cpu_ack, fill_busy, fill_done, fb_we);
      end
      checks++;
      if (fb_wa !== 13'h0 || fb_wd !== 8'h0) begin
         failures++;
         $display("FAIL reset_data: got wa=%h wd=%h want 0000/00", fb_wa, fb_wd);
      end
      rst_n = 1; cpu_req = 0; fill_start = 0;
      tick();
      checks++;
      if (fb_we !== 1'b0 || fill_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got we=%b busy=%b want 0/0", fb_we, fill_busy);
      end
   endtask

   task automatic test_cpu_alone();
      cpu_req = 1; cpu_wa = 13'h0A05; cpu_wd = 8'hE0;
      tick();
      checks++;
      if (fb_we !== 1 || cpu_ack !== 1 || fb_wa !== 13'h0A05 || fb_wd !== 8'hE0) begin
         failures++;
         $display("FAIL cpu_write: got we=%b ack=%b wa=%h wd=%h want 1/1/0a05/e0",
                  fb_we, cpu_ack, fb_wa, fb_wd);
      end
      tick();
      checks++;
      if (fb_we !== 0 || cpu_ack !== 0) begin
         failures++;
         $display("FAIL cpu_no_regrant: got we=%b ack=%b want 0/0", fb_we, cpu_ack);
      end
      cpu_req = 0;
      tick();
   endtask

   task automatic test_fill_alone();
      logic [12:0] exp_a[6];
      exp_a = '{pix(3, 2), pix(3, 3), pix(3, 4), pix(4, 2), pix(4, 3), pix(4, 4)};
      set_fill(2, 3, 3, 2, 8'h1C);
      fill_start = 1;
      tick();
      fill_start = 0;
      checks++;
      if (fill_busy !== 1 || fb_we !== 0) begin
         failures++;
         $display("FAIL fill_start_latency: got busy=%b we=%b want 1/0", fill_busy, fb_we);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (fb_we !== 1 || fb_wa !== exp_a[i] || fb_wd !== 8'h1C || fill_done !== (i == 5)) begin
            failures++;
            $display("FAIL fill_pixel%0d: got we=%b wa=%h wd=%h done=%b want 1/%h/1c/%b",
                     i, fb_we, fb_wa, fb_wd, fill_done, exp_a[i], (i == 5));
         end
      end
      tick();
      checks++;
      if (fill_busy !== 0 || fill_done !== 0 || fb_we !== 0) begin
         failures++;
         $display("FAIL fill_end: got busy=%b done=%b we=%b want 0/0/0",
                  fill_busy, fill_done, fb_we);
      end
   endtask

   task automatic test_contention();
      logic [12:0] fills[$];
      int          writes = 0;
      logic        first_cpu = 1'b0;
      logic        prev_cpu = 1'b0;
      int          cpu_twice = 0;
      set_fill(10, 5, 4, 1, 8'h3C);
      fill_start = 1;
      tick();
      fill_start = 0; cpu_req = 1; cpu_wa = 13'h0100; cpu_wd = 8'hA0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if ({cpu_ack, fill_busy, fill_done, fb_we, fb_wa, fb_wd} !==
             {e_ack, e_busy, e_done, e_we, e_wa, e_wd}) begin
            failures++;
            $display("FAIL contention_cyc%0d: got a%b b%b d%b w%b %h/%h want a%b b%b d%b w%b %h/%h",
                     i, cpu_ack, fill_busy, fill_done, fb_we, fb_wa, fb_wd,
                     e_ack, e_busy, e_done, e_we, e_wa, e_wd);
         end
         if (fb_we === 1'b1) begin
            if (writes == 0) first_cpu = cpu_ack;
            if (cpu_ack === 1'b1 && prev_cpu) cpu_twice++;
            prev_cpu = (cpu_ack === 1'b1);
            if (cpu_ack !== 1'b1) fills.push_back(fb_wa);
            writes++;
         end else begin
            prev_cpu = 1'b0;
         end
         if (e_ack) begin
            cpu_wa = cpu_wa + 13'd1;
            cpu_wd = cpu_wd + 8'd1;
         end
      end
      cpu_req = 0;
      tick();
      checks++;
      if (first_cpu !== 1'b1 || cpu_twice != 0) begin
         failures++;
         $display("FAIL contention_order: got first_cpu=%b cpu_back_to_back=%0d want 1/0",
                  first_cpu, cpu_twice);
      end
      checks++;
      if (fills.size() != 4) begin
         failures++;
         $display("FAIL contention_fill_count: got %0d want 4", fills.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (fills[k] !== pix(5, 10 + k)) begin
               failures++;
               $display("FAIL contention_fill%0d: got %h want %h", k, fills[k], pix(5, 10 + k));
            end
         end
      end
   endtask

   task automatic test_clip_zero();
      logic [12:0] seen[$];
      int          dones = 0;
      set_fill(78, 59, 4, 2, 8'hC3);
      fill_start = 1;
      tick();
      fill_start = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (fb_we === 1'b1) seen.push_back(fb_wa);
         if (fill_done === 1'b1) dones++;
      end
      checks++;
      if (seen.size() != 2 || dones != 1) begin
         failures++;
         $display("FAIL clip_count: got writes=%0d dones=%0d want 2/1", seen.size(), dones);
      end else begin
         checks++;
         if (seen[0] !== pix(59, 78) || seen[1] !== pix(59, 79)) begin
            failures++;
            $display("FAIL clip_addr: got %h,%h want %h,%h",
                     seen[0], seen[1], pix(59, 78), pix(59, 79));
         end
      end
      set_fill(5, 5, 0, 3, 8'h77);
      fill_start = 1;
      tick();
      fill_start = 0;
      checks++;
      if (fill_done !== 1 || fill_busy !== 1 || fb_we !== 0) begin
         failures++;
         $display("FAIL zero_width: got done=%b busy=%b we=%b want 1/1/0",
                  fill_done, fill_busy, fb_we);
      end
      tick();
      checks++;
      if (fill_done !== 0 || fill_busy !== 0 || fb_we !== 0) begin
         failures++;
         $display("FAIL zero_width_end: got done=%b busy=%b we=%b want 0/0/0",
                  fill_done, fill_busy, fb_we);
      end
   endtask

   task automatic test_busy_abort();
      logic [12:0] seen[$];
      int          dones = 0;
      int          bad = 0;
      set_fill(0, 10, 5, 1, 8'h11);
      fill_start = 1;
      tick();
      fill_start = 0;
      tick();
      if (fb_we === 1'b1) seen.push_back(fb_wa);
      set_fill(50, 0, 1, 1, 8'hEE);
      fill_start = 1;
      tick();
      fill_start = 0;
      if (fb_we === 1'b1) seen.push_back(fb_wa);
      if (fb_we === 1'b1 && fb_wd !== 8'h11) bad++;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (fb_we === 1'b1) seen.push_back(fb_wa);
         if (fb_we === 1'b1 && fb_wd !== 8'h11) bad++;
         if (fill_done === 1'b1) dones++;
      end
      checks++;
      if (seen.size() != 5 || dones != 1 || bad != 0) begin
         failures++;
         $display("FAIL busy_ignore: got writes=%0d dones=%0d badcolour=%0d want 5/1/0",
                  seen.size(), dones, bad);
      end else begin
         checks++;
         if (seen[4] !== pix(10, 4)) begin
            failures++;
            $display("FAIL busy_ignore_last: got %h want %h", seen[4], pix(10, 4));
         end
      end
      set_fill(0, 20, 20, 1, 8'h22);
      fill_start = 1;
      tick();
      fill_start = 0;
      repeat (3) tick();
      rst_n = 0;
      tick();
      checks++;
      if (fb_we !== 0 || fill_busy !== 0 || fill_done !== 0) begin
         failures++;
         $display("FAIL abort: got we=%b busy=%b done=%b want 0/0/0", fb_we, fill_busy, fill_done);
      end
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (fb_we !== 0 || fill_done !== 0 || fill_busy !== 0) begin
            failures++;
            $display("FAIL abort_after%0d: got we=%b done=%b busy=%b want 0/0/0",
                     i, fb_we, fill_done, fill_busy);
         end
      end
   endtask

   task automatic test_random();
      rst_n = 0; cpu_req = 0; fill_start = 0;
      tick();
      rst_n = 1;
      for (int i = 0; i < 4000; i++) begin
         if (!cpu_req) begin
            if ($urandom_range(0, 2) == 0) begin
               cpu_req = 1;
               cpu_wa  = 13'($urandom);
               cpu_wd  = 8'($urandom);
            end
         end else if (e_ack) begin
            cpu_req = 1'($urandom_range(0, 1));
            cpu_wa  = 13'($urandom);
            cpu_wd  = 8'($urandom);
         end
         fill_start = ($urandom_range(0, 15) == 0);
         fill_x     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(70, 127))
                                                   : 7'($urandom_range(0, 20));
         fill_y     = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(55, 63))
                                                   : 6'($urandom_range(0, 10));
         fill_w     = 7'($urandom_range(0, 10));
         fill_h     = 6'($urandom_range(0, 4));
         fill_color = 8'($urandom);
         rst_n      = ($urandom_range(0, 499) != 0);
         tick();
         checks++;
         if ({cpu_ack, fill_busy, fill_done, fb_we, fb_wa, fb_wd} !==
             {e_ack, e_busy, e_done, e_we, e_wa, e_wd}) begin
            failures++;
            $display("FAIL random_cyc%0d: got a%b b%b d%b w%b %h/%h want a%b b%b d%b w%b %h/%h",
                     i, cpu_ack, fill_busy, fill_done, fb_we, fb_wa, fb_wd,
                     e_ack, e_busy, e_done, e_we, e_wa, e_wd);
         end
      end
      rst_n = 1; cpu_req = 0; fill_start = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_cpu_alone();
      test_fill_alone();
      test_contention();
      test_clip_zero();
      test_busy_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
